// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU-side and response signals around alu_arbiter.
// slave: the arbiter's view; master: the requesters, ALU and response consumer.
interface alu_arbiter_if #(
  parameter int N = 4
);
  logic         req0_valid;
  logic         req0_ready;
  logic [3:0]   req0_ctrl;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic         req0_setflags;

  logic         req1_valid;
  logic         req1_ready;
  logic [3:0]   req1_ctrl;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         req1_setflags;

  logic [3:0]   alu_ctrl;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_result;
  logic [1:0]   alu_flags;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [N-1:0] rsp_result;
  logic [1:0]   rsp_flags;
  logic [1:0]   flags_q;

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b, req0_setflags,
    output req0_ready,
    input  req1_valid, req1_ctrl, req1_a, req1_b, req1_setflags,
    output req1_ready,
    output alu_ctrl, alu_a, alu_b,
    input  alu_result, alu_flags,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, flags_q,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b, req0_setflags,
    input  req0_ready,
    output req1_valid, req1_ctrl, req1_a, req1_b, req1_setflags,
    input  req1_ready,
    input  alu_ctrl, alu_a, alu_b,
    output alu_result, alu_flags,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, flags_q,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter for a shared N-bit ALU: grants, registers the op, captures the
// result/flags into a held response and maintains {V,Z}. Option: ALU_ARB_FIXED_PRIO_EN.
module alu_arbiter #(
  parameter int N = 4
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic         last_grant;
  logic         lat_id;
  logic         lat_setflags;

  logic         gnt_valid;
  logic         gnt_id;
  logic         accept;
  logic [3:0]   gnt_ctrl;
  logic [N-1:0] gnt_a;
  logic [N-1:0] gnt_b;
  logic         gnt_setflags;

  // Grant selection and operand mux for the winning port.
  always_comb begin
    gnt_valid = bus.req0_valid | bus.req1_valid;
    gnt_id    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt_id = 1'b0;
`else
      gnt_id = ~last_grant;
`endif
    end else begin
      gnt_id = bus.req1_valid;
    end
    gnt_ctrl     = gnt_id ? bus.req1_ctrl     : bus.req0_ctrl;
    gnt_a        = gnt_id ? bus.req1_a        : bus.req0_a;
    gnt_b        = gnt_id ? bus.req1_b        : bus.req0_b;
    gnt_setflags = gnt_id ? bus.req1_setflags : bus.req0_setflags;
  end

  assign accept = (state == IDLE) && gnt_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = accept && !gnt_id;
    bus.req1_ready = accept &&  gnt_id;
  end

  // alu_* hold the last op outside EXEC; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.alu_ctrl   <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      bus.flags_q    <= '0;
      last_grant     <= 1'b1;
      lat_id         <= 1'b0;
      lat_setflags   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.alu_ctrl <= gnt_ctrl;
            bus.alu_a    <= gnt_a;
            bus.alu_b    <= gnt_b;
            lat_id       <= gnt_id;
            lat_setflags <= gnt_setflags;
            last_grant   <= gnt_id;
          end
        end
        EXEC: begin
          bus.rsp_result <= bus.alu_result;
          bus.rsp_flags  <= bus.alu_flags;
          bus.rsp_id     <= lat_id;
          bus.rsp_valid  <= 1'b1;
          if (lat_setflags) bus.flags_q <= bus.alu_flags;
        end
        RESP: begin
          if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
